// File: rtl/snd_filt_mc.sv
// snd_filt_mc: time-multiplexed multi-channel first-order LP/HP filter with base/filtered blend and total gain.
// Define SND_FILT_CLIP_CNT_EN to add the clip_cnt output counting saturated channel results.
module snd_filt_mc #(
  parameter int CH       = 2,
  parameter int W        = 16,
  parameter int LP_SHIFT = 11,
  parameter int HP_SHIFT = 8,
  parameter int GT_SHIFT = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sample_sync,
  input  logic [CH*W-1:0] x_in,
  input  logic [CH-1:0]   mode,
  input  logic [CH*8-1:0] alpha,
  input  logic [CH*8-1:0] gain_base,
  input  logic [CH*8-1:0] gain_filt,
  input  logic [CH*8-1:0] gain_totl,
  input  logic            ovr_clr,
  output logic [CH*W-1:0] y_out,
  output logic            y_valid,
  output logic            busy,
  output logic            overrun
`ifdef SND_FILT_CLIP_CNT_EN
  ,
  output logic [15:0]     clip_cnt
`endif
);
  localparam int PW = W + 20;
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;
  localparam logic signed [PW-1:0] MAX_W  = (PW'(1) <<< (W-1)) - PW'(1);
  localparam logic signed [PW-1:0] MIN_W  = -(PW'(1) <<< (W-1));
  localparam logic signed [PW-1:0] MAX_W1 = (PW'(1) <<< W) - PW'(1);
  localparam logic signed [PW-1:0] MIN_W1 = -(PW'(1) <<< W);

  typedef enum logic [2:0] {S_IDLE, S_DIFF, S_INT, S_MIX, S_TOT, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          ch_q, ch_d;
  logic                   sync_q, sync_d;
  logic [CH*W-1:0]        x_f_q, x_f_d;
  logic [CH-1:0]          mode_f_q, mode_f_d;
  logic [CH*8-1:0]        alpha_f_q, alpha_f_d, gb_f_q, gb_f_d, gf_f_q, gf_f_d, gt_f_q, gt_f_d;
  logic signed [W+1:0]    d_q, d_d;
  logic signed [PW-1:0]   amp_q, amp_d;
  logic signed [W:0]      y_int_q [CH];
  logic signed [W:0]      y_int_d [CH];
  logic signed [W-1:0]    x_old_q [CH];
  logic signed [W-1:0]    x_old_d [CH];
  logic signed [W-1:0]    r_q [CH];
  logic signed [W-1:0]    r_d [CH];
  logic [CH*W-1:0]        y_out_q, y_out_d;
  logic                   pub_q, pub_d, y_valid_q, y_valid_d, ovr_q, ovr_d;

  logic                   start, mode_c;
  logic signed [W-1:0]    x_c;
  logic signed [PW-1:0]   x_e, yi_e, xo_e, al_e, gb_e, gf_e, gt_e, prod_e, tot_e;

  function automatic logic signed [W-1:0] sat_w(input logic signed [PW-1:0] v);
    if (v > MAX_W)      return W'(MAX_W);
    else if (v < MIN_W) return W'(MIN_W);
    else                return W'(v);
  endfunction

  function automatic logic signed [W:0] sat_w1(input logic signed [PW-1:0] v);
    if (v > MAX_W1)      return (W+1)'(MAX_W1);
    else if (v < MIN_W1) return (W+1)'(MIN_W1);
    else                 return (W+1)'(v);
  endfunction

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    sync_d    = sample_sync;
    x_f_d     = x_f_q;
    mode_f_d  = mode_f_q;
    alpha_f_d = alpha_f_q;
    gb_f_d    = gb_f_q;
    gf_f_d    = gf_f_q;
    gt_f_d    = gt_f_q;
    d_d       = d_q;
    amp_d     = amp_q;
    y_int_d   = y_int_q;
    x_old_d   = x_old_q;
    r_d       = r_q;
    pub_d     = 1'b0;
    y_valid_d = pub_q;
    y_out_d   = y_out_q;
    if (pub_q) begin
      for (int n = 0; n < CH; n++) y_out_d[n*W +: W] = r_q[n];
    end

    start = sample_sync & ~sync_q;
    // A start outside IDLE is dropped; setting the flag beats a simultaneous clear.
    if (start && (state_q != S_IDLE)) ovr_d = 1'b1;
    else if (ovr_clr)                 ovr_d = 1'b0;
    else                              ovr_d = ovr_q;

    mode_c = mode_f_q[ch_q];
    x_c    = x_f_q[ch_q*W +: W];
    x_e    = PW'(x_c);
    yi_e   = PW'(y_int_q[ch_q]);
    xo_e   = PW'(x_old_q[ch_q]);
    al_e   = PW'(alpha_f_q[ch_q*8 +: 8]);
    gb_e   = PW'(gb_f_q[ch_q*8 +: 8]);
    gf_e   = PW'(gf_f_q[ch_q*8 +: 8]);
    gt_e   = PW'(gt_f_q[ch_q*8 +: 8]);
    prod_e = '0;
    tot_e  = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          x_f_d     = x_in;
          mode_f_d  = mode;
          alpha_f_d = alpha;
          gb_f_d    = gain_base;
          gf_f_d    = gain_filt;
          gt_f_d    = gain_totl;
          ch_d      = '0;
          state_d   = S_DIFF;
        end
      end
      S_DIFF: begin
        if (mode_c) d_d = (W+2)'(yi_e + xo_e - x_e);
        else        d_d = (W+2)'(x_e - yi_e);
        state_d = S_INT;
      end
      S_INT: begin
        prod_e = al_e * PW'(d_q);
        if (mode_c) y_int_d[ch_q] = sat_w1(prod_e >>> HP_SHIFT);
        else        y_int_d[ch_q] = sat_w1(yi_e + (prod_e >>> LP_SHIFT));
        state_d = S_MIX;
      end
      S_MIX: begin
        amp_d   = (x_e * gb_e + yi_e * gf_e) >>> 7;
        state_d = S_TOT;
      end
      S_TOT: begin
        prod_e    = amp_q * gt_e;
        tot_e     = prod_e >>> GT_SHIFT;
        r_d[ch_q] = sat_w(tot_e);
        if (ch_q == CW'(CH-1)) begin
          state_d = S_DONE;
        end else begin
          ch_d    = ch_q + 1'b1;
          state_d = S_DIFF;
        end
      end
      S_DONE: begin
        for (int n = 0; n < CH; n++) x_old_d[n] = x_f_q[n*W +: W];
        pub_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ch_q      <= '0;
      sync_q    <= 1'b0;
      x_f_q     <= '0;
      mode_f_q  <= '0;
      alpha_f_q <= '0;
      gb_f_q    <= '0;
      gf_f_q    <= '0;
      gt_f_q    <= '0;
      d_q       <= '0;
      amp_q     <= '0;
      for (int n = 0; n < CH; n++) begin
        y_int_q[n] <= '0;
        x_old_q[n] <= '0;
        r_q[n]     <= '0;
      end
      y_out_q   <= '0;
      pub_q     <= 1'b0;
      y_valid_q <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      sync_q    <= sync_d;
      x_f_q     <= x_f_d;
      mode_f_q  <= mode_f_d;
      alpha_f_q <= alpha_f_d;
      gb_f_q    <= gb_f_d;
      gf_f_q    <= gf_f_d;
      gt_f_q    <= gt_f_d;
      d_q       <= d_d;
      amp_q     <= amp_d;
      y_int_q   <= y_int_d;
      x_old_q   <= x_old_d;
      r_q       <= r_d;
      y_out_q   <= y_out_d;
      pub_q     <= pub_d;
      y_valid_q <= y_valid_d;
      ovr_q     <= ovr_d;
    end
  end

  assign y_out   = y_out_q;
  assign y_valid = y_valid_q;
  assign busy    = (state_q != S_IDLE);
  assign overrun = ovr_q;

`ifdef SND_FILT_CLIP_CNT_EN
  logic [15:0] clip_q, clip_d;
  logic        clip_hit;

  always_comb begin
    clip_hit = (state_q == S_TOT) && ((tot_e > MAX_W) || (tot_e < MIN_W));
    clip_d   = clip_q;
    if (ovr_clr)                                  clip_d = '0;
    else if (clip_hit && (clip_q != 16'hFFFF))    clip_d = clip_q + 16'd1;
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) clip_q <= '0;
    else     clip_q <= clip_d;
  end

  assign clip_cnt = clip_q;
`endif
endmodule

// File: tb/tb_snd_filt_mc.sv
// Directed bench for snd_filt_mc (CH=2, W=16): frame table with hand-computed results plus
// overrun, mid-frame reset and held-sync sequences.
module tb_snd_filt_mc;
  localparam int CH = 2;
  localparam int W  = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            sample_sync = 1'b0;
  logic            ovr_clr = 1'b0;
  logic [CH*W-1:0] x_in = '0;
  logic [CH-1:0]   mode = '0;
  logic [CH*8-1:0] alpha = '0;
  logic [CH*8-1:0] gain_base = '0;
  logic [CH*8-1:0] gain_filt = '0;
  logic [CH*8-1:0] gain_totl = '0;
  logic [CH*W-1:0] y_out;
  logic            y_valid;
  logic            busy;
  logic            overrun;
`ifdef SND_FILT_CLIP_CNT_EN
  logic [15:0]     clip_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  snd_filt_mc #(.CH(CH), .W(W)) dut (
    .clk(clk), .rst(rst), .sample_sync(sample_sync), .x_in(x_in), .mode(mode),
    .alpha(alpha), .gain_base(gain_base), .gain_filt(gain_filt), .gain_totl(gain_totl),
    .ovr_clr(ovr_clr), .y_out(y_out), .y_valid(y_valid), .busy(busy), .overrun(overrun)
`ifdef SND_FILT_CLIP_CNT_EN
    , .clip_cnt(clip_cnt)
`endif
  );

  typedef struct packed {
    logic        m;
    logic [7:0]  a, gb, gf, gt;
    logic [15:0] x, e;
  } chv_t;

  typedef struct packed {
    logic do_rst;
    chv_t c0, c1;
  } vec_t;

  vec_t vecs[7];

  function automatic chv_t mk(input logic m, input int a, input int gb, input int gf,
                              input int gt, input int x, input int e);
    chv_t r;
    r.m = m; r.a = 8'(a); r.gb = 8'(gb); r.gf = 8'(gf); r.gt = 8'(gt);
    r.x = 16'(x); r.e = 16'(e);
    return r;
  endfunction

  function automatic vec_t mkv(input logic do_rst, input chv_t c0, input chv_t c1);
    vec_t v;
    v.do_rst = do_rst; v.c0 = c0; v.c1 = c1;
    return v;
  endfunction

  function automatic logic signed [63:0] sx(input logic [15:0] v);
    logic signed [15:0] s;
    s = v;
    return 64'(s);
  endfunction

  function automatic logic signed [63:0] yo(input int n);
    logic signed [15:0] s;
    s = y_out[n*W +: W];
    return 64'(s);
  endfunction

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic load(input int n, input chv_t c);
    mode[n]               = c.m;
    alpha[n*8 +: 8]       = c.a;
    gain_base[n*8 +: 8]   = c.gb;
    gain_filt[n*8 +: 8]   = c.gf;
    gain_totl[n*8 +: 8]   = c.gt;
    x_in[n*W +: W]        = c.x;
  endtask

  task automatic do_reset();
    @(posedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    rst = 1'b0;
  endtask

  // k counts negedges after the start edge; y_valid is expected at k=10.
  task automatic do_frame(output int lat, output int pulses);
    lat = -1;
    pulses = 0;
    @(posedge clk);
    sample_sync = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk);
      if (k == 0) sample_sync = 1'b0;
      if (y_valid) begin
        pulses++;
        if (lat < 0) lat = k;
      end
    end
  endtask

  int lat, pulses;

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = mkv(1'b1, mk(0,   0, 128,   0, 128,  -1234,  -1234), mk(0, 255,   0, 128, 128, 16384,   2040));
    vecs[1] = mkv(1'b0, mk(0,   0, 128,   0, 128,   1000,   1000), mk(0, 255,   0, 128, 128, 16384,   3825));
    vecs[2] = mkv(1'b1, mk(0,   0,   0, 128, 128,  16384,      0), mk(0,   0, 255,   0, 128, 30000,  32767));
    vecs[3] = mkv(1'b0, mk(1, 128,   0, 128, 128,      0,   8192), mk(0,   0, 255,   0, 128, -30000, -32768));
    vecs[4] = mkv(1'b0, mk(1, 128,   0, 128, 128,      0,   4096), mk(0,   0, 128,   0,  64,     -3,     -2));
    vecs[5] = mkv(1'b0, mk(1, 128,   0, 128, 128,      0,   2048), mk(0,   0,  64,   0, 255,   -101,   -102));
    vecs[6] = mkv(1'b0, mk(1, 255, 128, 128, 128,  16384,   2104), mk(0,   0, 128,   0,   0,   5000,      0));

    rst = 1'b1;
    repeat (3) @(posedge clk);
    chk("rst_y_out",   64'(y_out),   64'd0);
    chk("rst_y_valid", 64'(y_valid), 64'd0);
    chk("rst_busy",    64'(busy),    64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].do_rst) do_reset();
      @(posedge clk);
      load(0, vecs[i].c0);
      load(1, vecs[i].c1);
      do_frame(lat, pulses);
      chk($sformatf("v%0d_y0", i),     yo(0),       sx(vecs[i].c0.e));
      chk($sformatf("v%0d_y1", i),     yo(1),       sx(vecs[i].c1.e));
      chk($sformatf("v%0d_lat", i),    64'(lat),    64'd10);
      chk($sformatf("v%0d_pulses", i), 64'(pulses), 64'd1);
      chk($sformatf("v%0d_busy", i),   64'(busy),   64'd0);
    end
`ifdef SND_FILT_CLIP_CNT_EN
    chk("clip_cnt_two", 64'(clip_cnt), 64'd2);
`endif

    // Overrun: second rise three edges into the frame, plus a mid-frame x_in change.
    @(posedge clk);
    load(0, mk(0, 0, 128, 0, 128,  111, 0));
    load(1, mk(0, 0, 128, 0, 128, -222, 0));
    @(posedge clk);
    sample_sync = 1'b1;
    lat = -1;
    pulses = 0;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk);
      if (k == 0) begin sample_sync = 1'b0; x_in[W-1:0] = 16'd999; end
      if (k == 2) sample_sync = 1'b1;
      if (k == 3) sample_sync = 1'b0;
      if (k == 4) chk("ovr_busy_mid", 64'(busy), 64'd1);
      if (y_valid) begin
        pulses++;
        if (lat < 0) lat = k;
      end
    end
    chk("ovr_flag",   64'(overrun), 64'd1);
    chk("ovr_lat",    64'(lat),     64'd10);
    chk("ovr_pulses", 64'(pulses),  64'd1);
    chk("ovr_y0",     yo(0),        64'sd111);
    chk("ovr_y1",     yo(1),        -64'sd222);
    @(posedge clk); ovr_clr = 1'b1;
    @(posedge clk); ovr_clr = 1'b0;
    @(posedge clk);
    chk("ovr_cleared", 64'(overrun), 64'd0);
`ifdef SND_FILT_CLIP_CNT_EN
    chk("clip_cnt_cleared", 64'(clip_cnt), 64'd0);
`endif

    // Set and clear in the same cycle: set must win.
    @(posedge clk);
    sample_sync = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk);
      if (k == 0) sample_sync = 1'b0;
      if (k == 2) begin sample_sync = 1'b1; ovr_clr = 1'b1; end
      if (k == 3) begin sample_sync = 1'b0; ovr_clr = 1'b0; end
    end
    chk("ovr_set_wins", 64'(overrun), 64'd1);
    @(posedge clk); ovr_clr = 1'b1;
    @(posedge clk); ovr_clr = 1'b0;

    // sample_sync held high starts exactly one frame, using the updated x_in.
    @(posedge clk);
    sample_sync = 1'b1;
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      if (y_valid) pulses++;
    end
    sample_sync = 1'b0;
    chk("hold_pulses",  64'(pulses),  64'd1);
    chk("hold_overrun", 64'(overrun), 64'd0);
    chk("hold_y0",      yo(0),        64'sd999);

    // Reset mid-frame abandons the frame and clears filter state.
    @(posedge clk);
    load(0, mk(0, 255, 0, 128, 128, 16384, 0));
    load(1, mk(0, 255, 0, 128, 128, 16384, 0));
    @(posedge clk);
    sample_sync = 1'b1;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      if (k == 0) sample_sync = 1'b0;
      if (k == 4) rst = 1'b1;
      if (k == 5) begin
        chk("mid_rst_y_out",   64'(y_out),   64'd0);
        chk("mid_rst_busy",    64'(busy),    64'd0);
        chk("mid_rst_overrun", 64'(overrun), 64'd0);
      end
      if (k == 6) rst = 1'b0;
      if (y_valid) pulses++;
    end
    chk("mid_rst_no_valid", 64'(pulses), 64'd0);
    do_frame(lat, pulses);
    chk("post_rst_y0",  yo(0),       64'sd2040);
    chk("post_rst_y1",  yo(1),       64'sd2040);
    chk("post_rst_lat", 64'(lat),    64'd10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
